pipe_hazard_ctrl: RTL

- Central stall/flush/forwarding controller for the 5-stage RISC-V pipeline.
- Drives the enable and flush inputs of the PC and of the IF/ID, ID/EX, EX/ME and ME/WB pipeline registers.
- Detects load-use hazards, sequences branch-redirect flushes and freezes the pipe while data memory is not ready.
- Generates the EX-stage operand forwarding selects.

---
 rtl/pipe_hazard_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central stall / flush / forwarding controller for a 5-stage RISC-V pipe.
// It decides, every cycle, whether each pipeline register advances or
// captures a bubble, and which EX operand sources are forwarded.
//
// Parameters
//   FLUSH_CYCLES : cycles IF/ID and ID/EX are flushed after a taken
//                  branch/jump (1..3)
//   MEM_TIMEOUT  : maximum data-memory wait cycles before a forced release
//                  (1..255)
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   id_rs1/id_rs2, id_use_*     sources of the ID instruction and use flags
//   ex_rd, ex_is_load           destination / load flag of the EX instruction
//   ex_rs1/ex_rs2               sources of the EX instruction (forwarding)
//   ex_br_taken                 branch/jump resolved taken in EX
//   me_rd/wb_rd, *_ru_write     destinations and write flags of ME / WB
//   me_req, me_ready            data-memory request / completion
//   pc_en..exme_en              pipeline register advance enables
//   ifid_flush..mewb_flush      bubble insert on the next capture
//   fwd_a, fwd_b                00 reg file, 01 ME ALU result, 10 WB data
//   mem_err                     single-cycle pulse on memory-wait timeout
//
// Optional build macro
//   PIPE_HAZARD_CTRL_PERF_EN    adds 32-bit saturating stall_cnt/flush_cnt
//
// Enables, flushes, forwarding selects and mem_err are combinational from
// the registered state and the current inputs, so the response lands in
// the same cycle as the hazard it answers.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_is_load,
    input  logic [4:0] ex_rs1,
    input  logic [4:0] ex_rs2,
    input  logic       ex_br_taken,
    input  logic [4:0] me_rd,
    input  logic [4:0] wb_rd,
    input  logic       me_ru_write,
    input  logic       wb_ru_write,
    input  logic       me_req,
    input  logic       me_ready,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       idex_en,
    output logic       exme_en,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       mewb_flush,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
`endif
    output logic       mem_err
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_BR_FLUSH = 2'b10
    } state_t;

    // What the pipe does this cycle; the output process decodes it.
    typedef enum logic [2:0] {
        ACT_PASS     = 3'd0,
        ACT_FREEZE   = 3'd1,
        ACT_BRANCH   = 3'd2,
        ACT_LOAD_USE = 3'd3
    } act_t;

    localparam logic [1:0] FLUSH_MAX = 2'(FLUSH_CYCLES);
    localparam logic [7:0] WAIT_MAX  = 8'(MEM_TIMEOUT);

    state_t     state_q, state_d;
    logic [1:0] br_cnt_q, br_cnt_d;      // flush cycles already issued
    logic [7:0] wait_cnt_q, wait_cnt_d;  // frozen cycles already spent
    logic       lu_block_q, lu_block_d;  // load-use stall issued last cycle

    act_t       act_s;
    logic       mem_err_s;
    logic       mem_stall_s;
    logic       load_use_s;
    logic       timeout_s;
    logic       eval_run_s;
    logic       eval_flush_s;

    // Forwarding source for one EX operand; ME wins over WB, x0 never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] m_rd,
        input logic       m_wr,
        input logic [4:0] w_rd,
        input logic       w_wr
    );
        logic [1:0] sel;
        if (m_wr && (m_rd != 5'd0) && (m_rd == rs)) begin
            sel = 2'b01;
        end else if (w_wr && (w_rd != 5'd0) && (w_rd == rs)) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Hazard conditions shared by the next-state logic.
    always_comb begin
        mem_stall_s = me_req & ~me_ready;
        // The one-cycle block keeps a held load-use pattern from stalling twice:
        // after one stall the load has moved on and EX holds a bubble.
        load_use_s  = ex_is_load & (ex_rd != 5'd0) & ~lu_block_q &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) |
                       (id_use_rs2 & (id_rs2 == ex_rd)));
        // This frozen cycle is number wait_cnt_q+1; expire when it hits the limit.
        timeout_s   = (state_q == ST_MEM_WAIT) & ~me_ready &
                      (({1'b0, wait_cnt_q} + 9'd1) >= {1'b0, WAIT_MAX});
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            br_cnt_q   <= 2'd0;
            wait_cnt_q <= 8'd0;
            lu_block_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            br_cnt_q   <= br_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            lu_block_q <= lu_block_d;
        end
    end

    // Next-state logic: picks this cycle's action and the following state.
    always_comb begin
        state_d      = state_q;
        br_cnt_d     = br_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        lu_block_d   = 1'b0;
        act_s        = ACT_PASS;
        mem_err_s    = 1'b0;
        eval_run_s   = 1'b0;
        eval_flush_s = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mem_stall_s) begin
                    act_s      = ACT_FREEZE;
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = 8'd1;
                    lu_block_d = lu_block_q;
                end else begin
                    eval_run_s = 1'b1;
                end
            end
            ST_BR_FLUSH: begin
                // br_cnt_q is kept, so the flush sequence resumes after the wait.
                if (mem_stall_s) begin
                    act_s      = ACT_FREEZE;
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end else begin
                    eval_flush_s = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (me_ready || timeout_s) begin
                    // Release: this cycle behaves as a normal (unfrozen) cycle,
                    // without re-checking the memory that is being let go.
                    wait_cnt_d = 8'd0;
                    mem_err_s  = ~me_ready;
                    if (br_cnt_q != 2'd0) begin
                        eval_flush_s = 1'b1;
                    end else begin
                        eval_run_s = 1'b1;
                    end
                end else begin
                    act_s      = ACT_FREEZE;
                    lu_block_d = lu_block_q;
                    wait_cnt_d = (wait_cnt_q >= WAIT_MAX) ? WAIT_MAX : (wait_cnt_q + 8'd1);
                end
            end
            default: begin
                act_s      = ACT_FREEZE;
                state_d    = ST_RUN;
                br_cnt_d   = 2'd0;
                wait_cnt_d = 8'd0;
            end
        endcase

        if (eval_run_s) begin
            if (ex_br_taken) begin
                act_s = ACT_BRANCH;
                if (FLUSH_MAX > 2'd1) begin
                    state_d  = ST_BR_FLUSH;
                    br_cnt_d = 2'd1;
                end else begin
                    state_d  = ST_RUN;
                    br_cnt_d = 2'd0;
                end
            end else if (load_use_s) begin
                act_s      = ACT_LOAD_USE;
                state_d    = ST_RUN;
                lu_block_d = 1'b1;
            end else begin
                act_s   = ACT_PASS;
                state_d = ST_RUN;
            end
        end else if (eval_flush_s) begin
            // Wrong-path ID/EX contents: keep flushing, ignore load-use and branches.
            act_s = ACT_BRANCH;
            if (({1'b0, br_cnt_q} + 3'd1) >= {1'b0, FLUSH_MAX}) begin
                state_d  = ST_RUN;
                br_cnt_d = 2'd0;
            end else begin
                state_d  = ST_BR_FLUSH;
                br_cnt_d = br_cnt_q + 2'd1;
            end
        end else begin
            br_cnt_d = br_cnt_d;
        end
    end

    // Output decode; reset forces a fully flushed, frozen pipe.
    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exme_en    = 1'b0;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        mewb_flush = 1'b1;
        fwd_a      = 2'b00;
        fwd_b      = 2'b00;
        mem_err    = 1'b0;
        if (!rst_n) begin
            mem_err = 1'b0;
        end else begin
            fwd_a   = fwd_sel(ex_rs1, me_rd, me_ru_write, wb_rd, wb_ru_write);
            fwd_b   = fwd_sel(ex_rs2, me_rd, me_ru_write, wb_rd, wb_ru_write);
            mem_err = mem_err_s;
            case (act_s)
                ACT_PASS: begin
                    {pc_en, ifid_en, idex_en, exme_en} = 4'b1111;
                    {ifid_flush, idex_flush, mewb_flush} = 3'b000;
                end
                ACT_FREEZE: begin
                    // ME/WB gets a bubble so WB does not retire twice.
                    {pc_en, ifid_en, idex_en, exme_en} = 4'b0000;
                    {ifid_flush, idex_flush, mewb_flush} = 3'b001;
                end
                ACT_BRANCH: begin
                    {pc_en, ifid_en, idex_en, exme_en} = 4'b1111;
                    {ifid_flush, idex_flush, mewb_flush} = 3'b110;
                end
                ACT_LOAD_USE: begin
                    // Hold PC and IF/ID, bubble into ID/EX, let the load advance.
                    {pc_en, ifid_en, idex_en, exme_en} = 4'b0011;
                    {ifid_flush, idex_flush, mewb_flush} = 3'b010;
                end
                default: begin
                    {pc_en, ifid_en, idex_en, exme_en} = 4'b0000;
                    {ifid_flush, idex_flush, mewb_flush} = 3'b001;
                end
            endcase
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    // Saturating performance counter increments.
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (!pc_en && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end else begin
            perf_stall_d = perf_stall_q;
        end
        if (ifid_flush && rst_n && (perf_flush_q != 32'hFFFF_FFFF)) begin
            perf_flush_d = perf_flush_q + 32'd1;
        end else begin
            perf_flush_d = perf_flush_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= 32'd0;
            perf_flush_q <= 32'd0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign stall_cnt = perf_stall_q;
    assign flush_cnt = perf_flush_q;
`endif

endmodule
